// File: rtl/reg_file.sv
// reg_file: architectural register file for the single-cycle MIPS datapath.
// 2^ADDR_W x DATA_W registers, two combinational read ports and one clocked
// write port. Register 0 is hard-wired to zero. Trapping arithmetic that
// overflows suppresses write-back and raises a sticky ovf_trap flag, and
// ovf_addr records the destination of the first such write.
// Optional feature macro: REG_FILE_BYPASS_EN (write-through read bypass).
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              alu_overflow,
  input  logic              trap_on_ovf,
  input  logic              ovf_clr,
  output logic              ovf_trap,
  output logic [ADDR_W-1:0] ovf_addr
);

  localparam int NREG = 1 << ADDR_W;

  // Stored registers 1..NREG-1; register 0 has no storage.
  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [DATA_W-1:0] regs_d [1:NREG-1];
  // Read view including the constant-zero register 0.
  logic [DATA_W-1:0] view_s [0:NREG-1];

  logic              ovf_trap_q;
  logic              ovf_trap_d;
  logic [ADDR_W-1:0] ovf_addr_q;
  logic [ADDR_W-1:0] ovf_addr_d;

  logic              suppress_s;
  logic              commit_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;

  // Classify this cycle's write: suppressed by a trapping overflow, or committed.
  always_comb begin
    suppress_s = wr_en & trap_on_ovf & alu_overflow;
    commit_s   = wr_en & (wr_addr != {ADDR_W{1'b0}}) & ~(trap_on_ovf & alu_overflow);
  end

  // Build the read view; index 0 always reads zero.
  always_comb begin
    view_s[0] = {DATA_W{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      view_s[i] = regs_q[i];
    end
  end

  // Read port mux, optionally forwarding a committing write; zero while in reset.
  always_comb begin
    rd1_s = view_s[rs_addr];
    rd2_s = view_s[rt_addr];
`ifdef REG_FILE_BYPASS_EN
    if (commit_s && (rs_addr == wr_addr)) begin
      rd1_s = wr_data;
    end else begin
      rd1_s = view_s[rs_addr];
    end
    if (commit_s && (rt_addr == wr_addr)) begin
      rd2_s = wr_data;
    end else begin
      rd2_s = view_s[rt_addr];
    end
`endif
    if (reset) begin
      rd_data1 = {DATA_W{1'b0}};
      rd_data2 = {DATA_W{1'b0}};
    end else begin
      rd_data1 = rd1_s;
      rd_data2 = rd2_s;
    end
  end

  // Next register contents: only the addressed register takes a committed write.
  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      if (commit_s && (wr_addr == ADDR_W'(i))) begin
        regs_d[i] = wr_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Next trap state: a suppressed write sets the flag and beats a clear; the
  // address is captured only for the first event (or when re-armed by a clear).
  always_comb begin
    ovf_trap_d = ovf_trap_q;
    ovf_addr_d = ovf_addr_q;
    if (suppress_s) begin
      ovf_trap_d = 1'b1;
      if (!ovf_trap_q || ovf_clr) begin
        ovf_addr_d = wr_addr;
      end else begin
        ovf_addr_d = ovf_addr_q;
      end
    end else if (ovf_clr) begin
      ovf_trap_d = 1'b0;
    end else begin
      ovf_trap_d = ovf_trap_q;
    end
  end

  // State registers with synchronous reset taking priority over writes and clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      ovf_trap_q <= 1'b0;
      ovf_addr_q <= {ADDR_W{1'b0}};
    end else begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      ovf_trap_q <= ovf_trap_d;
      ovf_addr_q <= ovf_addr_d;
    end
  end

  assign ovf_trap = ovf_trap_q;
  assign ovf_addr = ovf_addr_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: expected values are pushed to a queue
// when stimulus is applied and popped when the outputs are sampled.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alu_overflow;
  logic        trap_on_ovf;
  logic        ovf_clr;
  logic        ovf_trap;
  logic [4:0]  ovf_addr;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] mdl [0:31];

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_overflow(alu_overflow), .trap_on_ovf(trap_on_ovf),
    .ovf_clr(ovf_clr), .ovf_trap(ovf_trap), .ovf_addr(ovf_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    alu_overflow = 1'b0; trap_on_ovf = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                          input logic trap, input logic ovf);
    wr_en = 1'b1; wr_addr = a; wr_data = d; trap_on_ovf = trap; alu_overflow = ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_idle(); rs_addr = 5'd0; rt_addr = 5'd0;
    tick(); tick();
    reset = 1'b0;
    do_write(5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    tick(); set_idle(); rs_addr = 5'd5; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL rst_pre_r5: got %h expected %h", rd_data1, exp); end
    // reset asserted together with a pending write: reset wins, write lost
    reset = 1'b1; do_write(5'd6, 32'hCAFEF00D, 1'b0, 1'b0); #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL rst_during_read: got %h expected %h", rd_data1, exp); end
    tick(); reset = 1'b0; set_idle(); rs_addr = 5'd5; rt_addr = 5'd6; #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL rst_r5: got %h expected %h", rd_data1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data2 !== exp) begin n_fail++; $display("FAIL rst_lost_r6: got %h expected %h", rd_data2, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, ovf_trap} !== exp) begin n_fail++; $display("FAIL rst_trap: got %h expected %h", ovf_trap, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({27'd0, ovf_addr} !== exp) begin n_fail++; $display("FAIL rst_addr: got %h expected %h", ovf_addr, exp); end
  endtask

  task automatic test_basic();
    do_write(5'd7, 32'h12345678, 1'b0, 1'b0); exp_q.push_back(32'h12345678);
    tick();
    do_write(5'd0, 32'hFFFFFFFF, 1'b0, 1'b0); exp_q.push_back(32'h0);
    tick(); set_idle(); rs_addr = 5'd7; rt_addr = 5'd0; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL basic_r7: got %h expected %h", rd_data1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data2 !== exp) begin n_fail++; $display("FAIL basic_r0: got %h expected %h", rd_data2, exp); end
  endtask

  task automatic test_overflow();
    do_write(5'd3, 32'h00000011, 1'b0, 1'b0); tick();
    do_write(5'd3, 32'h80000000, 1'b1, 1'b1);
    exp_q.push_back(32'h11); exp_q.push_back(32'h1); exp_q.push_back(32'd3);
    tick(); set_idle(); rs_addr = 5'd3; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL ovf_r3_kept: got %h expected %h", rd_data1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, ovf_trap} !== exp) begin n_fail++; $display("FAIL ovf_trap_set: got %h expected %h", ovf_trap, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({27'd0, ovf_addr} !== exp) begin n_fail++; $display("FAIL ovf_addr_first: got %h expected %h", ovf_addr, exp); end
    do_write(5'd9, 32'h00000055, 1'b1, 1'b1);
    exp_q.push_back(32'd3); exp_q.push_back(32'h0);
    tick(); set_idle(); rt_addr = 5'd9; #1;
    exp = exp_q.pop_front(); n_checks++;
    if ({27'd0, ovf_addr} !== exp) begin n_fail++; $display("FAIL ovf_addr_hold: got %h expected %h", ovf_addr, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data2 !== exp) begin n_fail++; $display("FAIL ovf_r9_kept: got %h expected %h", rd_data2, exp); end
  endtask

  task automatic test_nontrap();
    do_write(5'd3, 32'h80000000, 1'b0, 1'b1);
    exp_q.push_back(32'h80000000); exp_q.push_back(32'h1);
    tick(); set_idle(); rs_addr = 5'd3; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL nontrap_r3: got %h expected %h", rd_data1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, ovf_trap} !== exp) begin n_fail++; $display("FAIL nontrap_trap: got %h expected %h", ovf_trap, exp); end
  endtask

  task automatic test_clear_collision();
    do_write(5'd12, 32'h1, 1'b1, 1'b1); ovf_clr = 1'b1;
    exp_q.push_back(32'h1); exp_q.push_back(32'd12);
    tick(); set_idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, ovf_trap} !== exp) begin n_fail++; $display("FAIL coll_trap: got %h expected %h", ovf_trap, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({27'd0, ovf_addr} !== exp) begin n_fail++; $display("FAIL coll_addr: got %h expected %h", ovf_addr, exp); end
    ovf_clr = 1'b1; exp_q.push_back(32'h0);
    tick(); set_idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, ovf_trap} !== exp) begin n_fail++; $display("FAIL clr_trap: got %h expected %h", ovf_trap, exp); end
    // overflow without wr_en: no effect
    wr_en = 1'b0; wr_addr = 5'd20; trap_on_ovf = 1'b1; alu_overflow = 1'b1;
    exp_q.push_back(32'h0);
    tick(); set_idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, ovf_trap} !== exp) begin n_fail++; $display("FAIL noen_trap: got %h expected %h", ovf_trap, exp); end
    // suppressed write to r0 still traps and records index 0
    ovf_clr = 1'b0; do_write(5'd0, 32'h7, 1'b1, 1'b1);
    exp_q.push_back(32'h1); exp_q.push_back(32'd0);
    tick(); set_idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, ovf_trap} !== exp) begin n_fail++; $display("FAIL r0ovf_trap: got %h expected %h", ovf_trap, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({27'd0, ovf_addr} !== exp) begin n_fail++; $display("FAIL r0ovf_addr: got %h expected %h", ovf_addr, exp); end
  endtask

  task automatic test_rdw();
    do_write(5'd4, 32'h1, 1'b0, 1'b0); tick();
    do_write(5'd4, 32'h2, 1'b0, 1'b0); rs_addr = 5'd4; rt_addr = 5'd4;
`ifdef REG_FILE_BYPASS_EN
    exp_q.push_back(32'h2); exp_q.push_back(32'h2);
`else
    exp_q.push_back(32'h1); exp_q.push_back(32'h1);
`endif
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL rdw_same_p1: got %h expected %h", rd_data1, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data2 !== exp) begin n_fail++; $display("FAIL rdw_same_p2: got %h expected %h", rd_data2, exp); end
    exp_q.push_back(32'h2);
    tick(); set_idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL rdw_next: got %h expected %h", rd_data1, exp); end
    do_write(5'd4, 32'h1, 1'b0, 1'b0); tick();
    do_write(5'd4, 32'h2, 1'b1, 1'b1); exp_q.push_back(32'h1); #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL rdw_suppressed: got %h expected %h", rd_data1, exp); end
    exp_q.push_back(32'h1);
    tick(); set_idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL rdw_suppressed_next: got %h expected %h", rd_data1, exp); end
    do_write(5'd0, 32'hABCD0123, 1'b0, 1'b0); rs_addr = 5'd0; exp_q.push_back(32'h0); #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data1 !== exp) begin n_fail++; $display("FAIL rdw_r0: got %h expected %h", rd_data1, exp); end
    tick(); set_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    mdl[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      d = $urandom;
      do_write(i[4:0], d, 1'b0, 1'b0);
      mdl[i] = d;
      exp_q.push_back(d);
      tick();
    end
    set_idle();
    for (int i = 1; i < 32; i++) begin
      rs_addr = i[4:0];
      rt_addr = 5'(32 - i);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (rd_data1 !== exp) begin n_fail++; $display("FAIL b2b_p1 r%0d: got %h expected %h", i, rd_data1, exp); end
      n_checks++;
      if (rd_data2 !== mdl[32 - i]) begin n_fail++; $display("FAIL b2b_p2 r%0d: got %h expected %h", 32 - i, rd_data2, mdl[32 - i]); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0; set_idle();
    test_reset();
    test_basic();
    test_overflow();
    test_nontrap();
    test_clear_collision();
    test_rdw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
